// File: rtl/dram_app_pkg.sv
// Shared constants and state encoding for the MIG app-interface burst arbiter.
package dram_app_pkg;

  localparam logic [2:0] APP_CMD_WR = 3'b000;
  localparam logic [2:0] APP_CMD_RD = 3'b001;

  typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD} dram_arb_st_t;

endpackage

// File: rtl/dram_app_burst_arb.sv
// Round-robin write/read burst arbiter onto the MIG 7-series native app interface,
// with a bounded outstanding-read counter and a registered read return path.
module dram_app_burst_arb
  import dram_app_pkg::*;
#(
  parameter int DRAM_ADDR_WIDTH     = 25,
  parameter int DRAM_APP_DATA_WIDTH = 512,
  parameter int DRAM_APP_MASK_WIDTH = 64,
  parameter int DRAM_APP_CMD_WIDTH  = 3,
  parameter int RD_MAX_OUTSTANDING  = 16
) (
  input  logic                                       dram_clk,
  input  logic                                       dram_rst,
  input  logic                                       dram_init_calib_complete,
  input  logic                                       wr_valid,
  output logic                                       wr_ready,
  input  logic [DRAM_ADDR_WIDTH-1:0]                 wr_addr,
  input  logic [DRAM_APP_DATA_WIDTH-1:0]             wr_data,
  input  logic [DRAM_APP_MASK_WIDTH-1:0]             wr_mask,
  input  logic                                       rd_valid,
  output logic                                       rd_ready,
  input  logic [DRAM_ADDR_WIDTH-1:0]                 rd_addr,
  output logic [DRAM_APP_DATA_WIDTH-1:0]             rd_data,
  output logic                                       rd_data_valid,
  output logic [DRAM_ADDR_WIDTH-1:0]                 dram_addr,
  output logic [DRAM_APP_CMD_WIDTH-1:0]              dram_app_cmd,
  output logic                                       dram_app_en,
  input  logic                                       dram_app_rdy,
  output logic [DRAM_APP_DATA_WIDTH-1:0]             dram_app_wdf_data,
  output logic [DRAM_APP_MASK_WIDTH-1:0]             dram_app_wdf_mask,
  output logic                                       dram_app_wdf_wren,
  output logic                                       dram_app_wdf_end,
  input  logic                                       dram_app_wdf_rdy,
  input  logic [DRAM_APP_DATA_WIDTH-1:0]             dram_app_rd_data,
  input  logic                                       dram_app_rd_data_valid,
  input  logic                                       dram_app_rd_data_end,
  output logic [$clog2(RD_MAX_OUTSTANDING+1)-1:0]    rd_outstanding,
  output logic                                       busy
);

  localparam int CW = $clog2(RD_MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] RD_MAX = CW'(RD_MAX_OUTSTANDING);

  dram_arb_st_t                   state_q, state_d;
  logic                           last_rd_q, last_rd_d;
  logic                           cmd_done_q, cmd_done_d;
  logic                           data_done_q, data_done_d;
  logic [DRAM_ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [DRAM_APP_DATA_WIDTH-1:0] data_q, data_d;
  logic [DRAM_APP_MASK_WIDTH-1:0] mask_q, mask_d;
  logic [CW-1:0]                  rd_cnt_q, rd_cnt_d;
  logic [DRAM_APP_DATA_WIDTH-1:0] rd_data_q;
  logic                           rd_data_valid_q;

  logic rd_elig, grant_wr, grant_rd, rd_cmd_hs, rd_ret;

  // Round-robin: with both sides eligible, the side not granted last wins.
  always_comb begin
    rd_elig  = rd_valid && (rd_cnt_q < RD_MAX);
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (state_q == ST_IDLE && dram_init_calib_complete && !dram_rst) begin
      grant_wr = wr_valid && (!rd_elig || last_rd_q);
      grant_rd = rd_elig && !grant_wr;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_rd_d   = last_rd_q;
    cmd_done_d  = cmd_done_q;
    data_done_d = data_done_q;
    addr_d      = addr_q;
    data_d      = data_q;
    mask_d      = mask_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_wr) begin
          state_d     = ST_WR;
          addr_d      = wr_addr;
          data_d      = wr_data;
          mask_d      = wr_mask;
          last_rd_d   = 1'b0;
          cmd_done_d  = 1'b0;
          data_done_d = 1'b0;
        end else if (grant_rd) begin
          state_d   = ST_RD;
          addr_d    = rd_addr;
          last_rd_d = 1'b1;
        end
      end
      // Command and write data handshake independently; leave once both are done.
      ST_WR: begin
        cmd_done_d  = cmd_done_q | dram_app_rdy;
        data_done_d = data_done_q | dram_app_wdf_rdy;
        if (cmd_done_d && data_done_d) state_d = ST_IDLE;
      end
      ST_RD: begin
        if (dram_app_rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rd_cmd_hs = (state_q == ST_RD) && dram_app_rdy;
  assign rd_ret    = dram_app_rd_data_valid && dram_app_rd_data_end;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    if (rd_cmd_hs && !rd_ret && rd_cnt_q < RD_MAX) rd_cnt_d = rd_cnt_q + CW'(1);
    else if (!rd_cmd_hs && rd_ret && rd_cnt_q != '0) rd_cnt_d = rd_cnt_q - CW'(1);
  end

  always_ff @(posedge dram_clk or posedge dram_rst) begin
    if (dram_rst) begin
      state_q         <= ST_IDLE;
      last_rd_q       <= 1'b1;
      cmd_done_q      <= 1'b0;
      data_done_q     <= 1'b0;
      addr_q          <= '0;
      data_q          <= '0;
      mask_q          <= '0;
      rd_cnt_q        <= '0;
      rd_data_q       <= '0;
      rd_data_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_rd_q       <= last_rd_d;
      cmd_done_q      <= cmd_done_d;
      data_done_q     <= data_done_d;
      addr_q          <= addr_d;
      data_q          <= data_d;
      mask_q          <= mask_d;
      rd_cnt_q        <= rd_cnt_d;
      rd_data_q       <= dram_app_rd_data;
      rd_data_valid_q <= dram_app_rd_data_valid;
    end
  end

  // A read return with nothing outstanding means the MIG and this block disagree.
  assert property (@(posedge dram_clk) disable iff (dram_rst)
    !(rd_ret && !rd_cmd_hs && rd_cnt_q == '0));

  assign wr_ready          = grant_wr;
  assign rd_ready          = grant_rd;
  assign dram_addr         = addr_q;
  assign dram_app_en       = ((state_q == ST_WR) && !cmd_done_q) || (state_q == ST_RD);
  assign dram_app_cmd      = (state_q == ST_RD) ? APP_CMD_RD : APP_CMD_WR;
  assign dram_app_wdf_data = data_q;
  assign dram_app_wdf_mask = mask_q;
  assign dram_app_wdf_wren = (state_q == ST_WR) && !data_done_q;
  assign dram_app_wdf_end  = dram_app_wdf_wren;
  assign rd_data           = rd_data_q;
  assign rd_data_valid     = rd_data_valid_q;
  assign rd_outstanding    = rd_cnt_q;
  assign busy              = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dram_app_burst_arb.sv
// Directed bench for dram_app_burst_arb with RD_MAX_OUTSTANDING = 4.
module tb_dram_app_burst_arb;

  localparam int AW = 25;
  localparam int DW = 512;
  localparam int MW = 64;
  localparam int CW = 3;

  logic          dram_clk = 1'b0;
  logic          dram_rst;
  logic          dram_init_calib_complete;
  logic          wr_valid, wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [MW-1:0] wr_mask;
  logic          rd_valid, rd_ready;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid;
  logic [AW-1:0] dram_addr;
  logic [2:0]    dram_app_cmd;
  logic          dram_app_en, dram_app_rdy;
  logic [DW-1:0] dram_app_wdf_data;
  logic [MW-1:0] dram_app_wdf_mask;
  logic          dram_app_wdf_wren, dram_app_wdf_end, dram_app_wdf_rdy;
  logic [DW-1:0] dram_app_rd_data;
  logic          dram_app_rd_data_valid, dram_app_rd_data_end;
  logic [CW-1:0] rd_outstanding;
  logic          busy;

  int n_vec = 0;
  int n_bad = 0;

  dram_app_burst_arb #(
    .DRAM_ADDR_WIDTH(AW), .DRAM_APP_DATA_WIDTH(DW), .DRAM_APP_MASK_WIDTH(MW),
    .DRAM_APP_CMD_WIDTH(3), .RD_MAX_OUTSTANDING(4)
  ) dut (
    .dram_clk(dram_clk), .dram_rst(dram_rst),
    .dram_init_calib_complete(dram_init_calib_complete),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_mask(wr_mask),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .dram_addr(dram_addr), .dram_app_cmd(dram_app_cmd), .dram_app_en(dram_app_en),
    .dram_app_rdy(dram_app_rdy), .dram_app_wdf_data(dram_app_wdf_data),
    .dram_app_wdf_mask(dram_app_wdf_mask), .dram_app_wdf_wren(dram_app_wdf_wren),
    .dram_app_wdf_end(dram_app_wdf_end), .dram_app_wdf_rdy(dram_app_wdf_rdy),
    .dram_app_rd_data(dram_app_rd_data), .dram_app_rd_data_valid(dram_app_rd_data_valid),
    .dram_app_rd_data_end(dram_app_rd_data_end),
    .rd_outstanding(rd_outstanding), .busy(busy)
  );

  always #5 dram_clk = ~dram_clk;

  task automatic step();
    @(posedge dram_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    dram_rst = 1'b1;
    dram_init_calib_complete = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
    rd_valid = 1'b0; rd_addr = '0;
    dram_app_rdy = 1'b0; dram_app_wdf_rdy = 1'b0;
    dram_app_rd_data = '0; dram_app_rd_data_valid = 1'b0; dram_app_rd_data_end = 1'b0;
    step(); step(); step();
    settle();
    n_vec++; if ({dram_app_en, dram_app_wdf_wren, dram_app_wdf_end, busy} !== 4'b0000) begin n_bad++; $display("FAIL reset_ctrl: en/wren/end/busy=%b want 0000", {dram_app_en, dram_app_wdf_wren, dram_app_wdf_end, busy}); end
    n_vec++; if ({wr_ready, rd_ready, rd_data_valid} !== 3'b000) begin n_bad++; $display("FAIL reset_ready: wr/rd/rdv=%b want 000", {wr_ready, rd_ready, rd_data_valid}); end
    n_vec++; if (rd_outstanding !== 3'd0 || dram_addr !== '0 || dram_app_cmd !== 3'b000) begin n_bad++; $display("FAIL reset_regs: cnt=%0d addr=%h cmd=%b want 0", rd_outstanding, dram_addr, dram_app_cmd); end
    dram_rst = 1'b0;
    step();
  endtask

  task automatic test_calib_gate();
    logic seen;
    seen = 1'b0;
    wr_valid = 1'b1; wr_addr = 25'h1ABCDEF; wr_data = {16{32'hDEADBEEF}}; wr_mask = 64'h0F;
    for (int i = 0; i < 100; i++) begin
      settle();
      if (wr_ready !== 1'b0 || dram_app_en !== 1'b0) seen = 1'b1;
      step();
    end
    n_vec++; if (seen !== 1'b0) begin n_bad++; $display("FAIL calib_block: activity seen=%b want 0", seen); end
    dram_init_calib_complete = 1'b1;
    settle();
    n_vec++; if ({wr_ready, dram_app_en} !== 2'b10) begin n_bad++; $display("FAIL calib_grant: wr_ready/en=%b want 10", {wr_ready, dram_app_en}); end
    step();
    wr_valid = 1'b0;
    settle();
    n_vec++; if ({wr_ready, dram_app_en, dram_app_cmd} !== 5'b01000) begin n_bad++; $display("FAIL calib_cmd: ready/en/cmd=%b want 01000", {wr_ready, dram_app_en, dram_app_cmd}); end
    n_vec++; if (dram_addr !== 25'h1ABCDEF || dram_app_wdf_mask !== 64'h0F) begin n_bad++; $display("FAIL calib_addr: addr=%h mask=%h want 1abcdef/0f", dram_addr, dram_app_wdf_mask); end
    dram_app_rdy = 1'b1; dram_app_wdf_rdy = 1'b1;
    step();
    settle();
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL wr_same_cycle_done: busy=%b want 0", busy); end
  endtask

  task automatic test_wr_split();
    logic [DW-1:0] d;
    d = {8{64'h0123456789ABCDEF}};
    wr_valid = 1'b1; wr_addr = 25'h0000055; wr_data = d; wr_mask = 64'hFF00;
    dram_app_rdy = 1'b1; dram_app_wdf_rdy = 1'b0;
    settle();
    n_vec++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL wdf_late_grant: wr_ready=%b want 1", wr_ready); end
    step();
    wr_valid = 1'b0; wr_data = ~d;
    for (int i = 1; i <= 6; i++) begin
      if (i == 6) dram_app_wdf_rdy = 1'b1;
      settle();
      n_vec++; if ({dram_app_en, dram_app_wdf_wren, dram_app_wdf_end} !== {(i == 1), 2'b11}) begin n_bad++; $display("FAIL wdf_late_c%0d: en/wren/end=%b want %b", i, {dram_app_en, dram_app_wdf_wren, dram_app_wdf_end}, {(i == 1), 2'b11}); end
      n_vec++; if (dram_app_wdf_data !== d || dram_app_wdf_mask !== 64'hFF00) begin n_bad++; $display("FAIL wdf_late_hold_c%0d: data changed mask=%h want ff00", i, dram_app_wdf_mask); end
      step();
    end
    settle();
    n_vec++; if ({busy, dram_app_wdf_wren} !== 2'b00) begin n_bad++; $display("FAIL wdf_late_done: busy/wren=%b want 00", {busy, dram_app_wdf_wren}); end
    wr_valid = 1'b1; wr_addr = 25'h0000066;
    dram_app_rdy = 1'b0; dram_app_wdf_rdy = 1'b1;
    settle();
    n_vec++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL cmd_late_grant: wr_ready=%b want 1", wr_ready); end
    step();
    wr_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) dram_app_rdy = 1'b1;
      settle();
      n_vec++; if ({dram_app_en, dram_app_wdf_wren} !== {1'b1, (i == 1)}) begin n_bad++; $display("FAIL cmd_late_c%0d: en/wren=%b want %b", i, {dram_app_en, dram_app_wdf_wren}, {1'b1, (i == 1)}); end
      step();
    end
    settle();
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL cmd_late_done: busy=%b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp;
    dram_rst = 1'b1; step(); dram_rst = 1'b0;
    wr_valid = 1'b1; rd_valid = 1'b1; wr_addr = 25'h10; rd_addr = 25'h20;
    dram_app_rdy = 1'b1; dram_app_wdf_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      settle();
      exp = (i % 4 == 0) ? 2'b10 : (i % 4 == 2) ? 2'b01 : 2'b00;
      n_vec++; if ({wr_ready, rd_ready, busy} !== {exp, (i % 2 == 1)}) begin n_bad++; $display("FAIL b2b_c%0d: wr/rd/busy=%b want %b", i, {wr_ready, rd_ready, busy}, {exp, (i % 2 == 1)}); end
      step();
    end
    wr_valid = 1'b0; rd_valid = 1'b0;
    settle();
    n_vec++; if (rd_outstanding !== 3'd2) begin n_bad++; $display("FAIL b2b_outstanding: cnt=%0d want 2", rd_outstanding); end
    dram_app_rd_data_valid = 1'b1; dram_app_rd_data_end = 1'b1;
    step(); step();
    dram_app_rd_data_valid = 1'b0; dram_app_rd_data_end = 1'b0;
    settle();
    n_vec++; if (rd_outstanding !== 3'd0) begin n_bad++; $display("FAIL b2b_drain: cnt=%0d want 0", rd_outstanding); end
  endtask

  task automatic test_rd_limit();
    int nacc;
    nacc = 0;
    rd_valid = 1'b1; rd_addr = 25'h40; dram_app_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      settle();
      if (rd_ready === 1'b1) nacc++;
      step();
    end
    settle();
    n_vec++; if (nacc !== 4) begin n_bad++; $display("FAIL limit_issued: reads=%0d want 4", nacc); end
    n_vec++; if ({rd_outstanding, rd_ready} !== {3'd4, 1'b0}) begin n_bad++; $display("FAIL limit_full: cnt=%0d rd_ready=%b want 4/0", rd_outstanding, rd_ready); end
    dram_app_rd_data_valid = 1'b1; dram_app_rd_data_end = 1'b1;
    settle();
    n_vec++; if (rd_ready !== 1'b0) begin n_bad++; $display("FAIL limit_ret_same: rd_ready=%b want 0", rd_ready); end
    step();
    dram_app_rd_data_valid = 1'b0; dram_app_rd_data_end = 1'b0;
    settle();
    n_vec++; if ({rd_outstanding, rd_ready} !== {3'd3, 1'b1}) begin n_bad++; $display("FAIL limit_reopen: cnt=%0d rd_ready=%b want 3/1", rd_outstanding, rd_ready); end
    step();
    rd_valid = 1'b0;
    dram_app_rd_data_valid = 1'b1; dram_app_rd_data_end = 1'b1;
    settle();
    n_vec++; if ({dram_app_en, dram_app_cmd} !== 4'b1001) begin n_bad++; $display("FAIL limit_cmd: en/cmd=%b want 1001", {dram_app_en, dram_app_cmd}); end
    step();
    dram_app_rd_data_valid = 1'b0; dram_app_rd_data_end = 1'b0;
    settle();
    n_vec++; if (rd_outstanding !== 3'd3) begin n_bad++; $display("FAIL limit_inc_dec: cnt=%0d want 3", rd_outstanding); end
    dram_app_rd_data_valid = 1'b1; dram_app_rd_data_end = 1'b1;
    step(); step(); step();
    dram_app_rd_data_valid = 1'b0; dram_app_rd_data_end = 1'b0;
    settle();
    n_vec++; if (rd_outstanding !== 3'd0) begin n_bad++; $display("FAIL limit_drain: cnt=%0d want 0", rd_outstanding); end
  endtask

  task automatic test_rd_data();
    logic [DW-1:0] pat;
    pat = {64{8'hA5}};
    rd_valid = 1'b1; rd_addr = 25'h0123456; dram_app_rdy = 1'b1;
    settle();
    n_vec++; if (rd_ready !== 1'b1) begin n_bad++; $display("FAIL rdd_grant: rd_ready=%b want 1", rd_ready); end
    step();
    rd_valid = 1'b0;
    settle();
    n_vec++; if (dram_addr !== 25'h0123456 || {dram_app_en, dram_app_cmd} !== 4'b1001) begin n_bad++; $display("FAIL rdd_cmd: addr=%h en/cmd=%b want 0123456/1001", dram_addr, {dram_app_en, dram_app_cmd}); end
    step();
    dram_app_rd_data = pat; dram_app_rd_data_valid = 1'b1; dram_app_rd_data_end = 1'b1;
    settle();
    n_vec++; if (rd_data_valid !== 1'b0) begin n_bad++; $display("FAIL rdd_latency: rd_data_valid=%b want 0", rd_data_valid); end
    step();
    dram_app_rd_data = '0; dram_app_rd_data_valid = 1'b0; dram_app_rd_data_end = 1'b0;
    settle();
    n_vec++; if (rd_data_valid !== 1'b1 || rd_data !== pat) begin n_bad++; $display("FAIL rdd_beat: valid=%b data=%h want 1/a5..", rd_data_valid, rd_data[63:0]); end
    n_vec++; if (rd_outstanding !== 3'd0) begin n_bad++; $display("FAIL rdd_count: cnt=%0d want 0", rd_outstanding); end
    step();
    settle();
    n_vec++; if (rd_data_valid !== 1'b0) begin n_bad++; $display("FAIL rdd_pulse: rd_data_valid=%b want 0", rd_data_valid); end
  endtask

  task automatic test_reset_midop();
    rd_valid = 1'b1; rd_addr = 25'h77; dram_app_rdy = 1'b1; dram_app_wdf_rdy = 1'b0;
    step();
    rd_valid = 1'b0;
    step();
    wr_valid = 1'b1; wr_addr = 25'h1234; wr_data = {16{32'hCAFEF00D}}; wr_mask = 64'h3;
    step();
    wr_valid = 1'b0;
    step(); step();
    settle();
    n_vec++; if ({dram_app_wdf_wren, rd_outstanding} !== {1'b1, 3'd1}) begin n_bad++; $display("FAIL rstmid_pre: wren=%b cnt=%0d want 1/1", dram_app_wdf_wren, rd_outstanding); end
    #2;
    dram_rst = 1'b1;
    #1;
    n_vec++; if ({dram_app_en, dram_app_wdf_wren, dram_app_wdf_end, busy, wr_ready} !== 5'b00000) begin n_bad++; $display("FAIL rstmid_ctrl: en/wren/end/busy/wr_ready=%b want 00000", {dram_app_en, dram_app_wdf_wren, dram_app_wdf_end, busy, wr_ready}); end
    n_vec++; if (rd_outstanding !== 3'd0 || dram_addr !== '0 || dram_app_wdf_data !== '0 || dram_app_wdf_mask !== '0) begin n_bad++; $display("FAIL rstmid_regs: cnt=%0d addr=%h mask=%h want 0", rd_outstanding, dram_addr, dram_app_wdf_mask); end
    step();
    dram_rst = 1'b0;
    dram_app_wdf_rdy = 1'b1;
    wr_valid = 1'b1; wr_addr = 25'h0BEEF;
    settle();
    n_vec++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_resume_grant: wr_ready=%b want 1", wr_ready); end
    step();
    wr_valid = 1'b0;
    settle();
    n_vec++; if (dram_app_en !== 1'b1 || dram_addr !== 25'h0BEEF) begin n_bad++; $display("FAIL rstmid_resume_cmd: en=%b addr=%h want 1/00beef", dram_app_en, dram_addr); end
    step();
    settle();
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_resume_done: busy=%b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_calib_gate();
    test_wr_split();
    test_back_to_back();
    test_rd_limit();
    test_rd_data();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
